cfg_serial_tx: RTL and testbench
================================

# cfg_serial_tx

FPGA-side initiator of the backend configuration link. It releases the backend from reset and waits for the backend to report ready. It then shifts configuration words out MSB-first on a slow serial clock and data pair that the backend receiver samples. It also synchronises the backend's `vco1_fast` status flag into the FPGA clock domain.

## Interface
Parameters:
- `DATA_W`, default 8: bits per configuration frame.
- `SCLK_DIV`, default 2: `i_mainclk` cycles per `o_sclk` half-period; minimum 1.
- `GAP_CYCLES`, default 4: `i_mainclk` cycles of idle (`o_sclk` low) enforced after each frame; minimum 1.
- `RST_HOLD`, default 4: `i_mainclk` cycles `o_resetbAll` is held low after reset release; minimum 1.

Ports:
- `i_mainclk`, input, 1: single clock. All logic is on the rising edge.
- `i_resetbFPGA`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: one-cycle request to send `i_data`. Accepted only when `o_busy`=0.
- `i_data`, input, `DATA_W`: frame payload. Captured on the accepting edge.
- `i_ready`, input, 1: backend ready. Same clock domain; used unsynchronised.
- `i_vco1_fast`, input, 1: backend VCO status. Asynchronous.
- `o_resetbAll`, output, 1: active-low reset to the backend.
- `o_sclk`, output, 1: serial clock. Idles low.
- `o_sdout`, output, 1: serial data. Changes only while `o_sclk` is low.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_done`, output, 1: one-cycle pulse when a frame completes.
- `o_err`, output, 1: one-cycle pulse when a frame is aborted.
- `o_vco1_fast_sync`, output, 1: `i_vco1_fast` after a 2-flop synchroniser.

## Operation
- States: RST_WAIT, WAIT_READY, IDLE, SHIFT, GAP. Every output is registered.
- Reset values: state=RST_WAIT; `o_resetbAll`=0, `o_sclk`=0, `o_sdout`=0, `o_busy`=1, `o_done`=0, `o_err`=0, `o_vco1_fast_sync`=0; synchroniser flops=0.
- RST_WAIT: counts `RST_HOLD` cycles, then sets `o_resetbAll`=1 and moves to WAIT_READY. `o_resetbAll` stays 1 until the next `i_resetbFPGA` assertion.
- WAIT_READY: goes to IDLE on the first edge where `i_ready`=1.
- IDLE:
  - `o_busy`=0.
  - `i_start`=1 loads the shift register with `i_data`, clears the divider and bit counters, and moves to SHIFT.
  - `i_ready`=0 in IDLE returns the block to WAIT_READY.
- SHIFT:
  - The divider counts 0..2·`SCLK_DIV`−1 per bit.
  - At count 0: `o_sdout` is set to the current MSB and `o_sclk` is 0.
  - At count `SCLK_DIV`: `o_sclk` goes to 1. The backend samples on this rising edge.
  - At wrap: the shift register shifts left and the bit counter increments.
  - After bit `DATA_W`−1 completes, `o_sclk` goes to 0, `o_sdout` goes to 0, and the block moves to GAP.
- GAP: holds `o_sclk`=0 for `GAP_CYCLES`, then pulses `o_done` and enters IDLE on the same edge.
- Abort:
  - `i_ready`=0 sampled in SHIFT or GAP forces `o_sclk`=0 and `o_sdout`=0 on the next edge.
  - It pulses `o_err` and moves to WAIT_READY.
  - `o_done` is not pulsed.
- `i_start` while `o_busy`=1 is ignored and not queued. `i_data` is ignored outside the accepting edge.
- Simultaneous `i_start`=1 and `i_ready`=0 in IDLE: `i_ready` wins. Go to WAIT_READY, no frame.
- Asynchronous reset mid-frame: all outputs and state return to reset values immediately, without waiting for a clock edge.

## Timing
- `i_start` accepted at edge N:
  - `o_busy`=1 and `o_sdout`=`i_data[DATA_W-1]` from edge N+1.
  - First `o_sclk` rise at edge N+1+`SCLK_DIV`.
- Bit k: `o_sdout` valid from edge N+1+2k·`SCLK_DIV`. `o_sclk` rises `SCLK_DIV` cycles later. Data setup and hold around each rise are both ≥`SCLK_DIV` cycles.
- Frame length: 2·`SCLK_DIV`·`DATA_W` cycles. GAP entered at edge N+1+2·`SCLK_DIV`·`DATA_W`.
- `o_done` pulse and `o_busy`=0: edge N+1+2·`SCLK_DIV`·`DATA_W`+`GAP_CYCLES`. With defaults this is N+37. The next `i_start` is accepted on that same edge or later.
- `o_vco1_fast_sync` latency: 2–3 cycles from an `i_vco1_fast` change.
- Abort latency: 1 cycle from `i_ready` falling to `o_err` and `o_sclk`=0.

## Test plan
Defaults unless noted.
- **Reset release.** `i_resetbFPGA` 0→1 at edge 0 with `i_ready`=0 → `o_resetbAll` rises at edge 4. `o_busy` stays 1 until `i_ready`=1, then falls 1 cycle later.
- **Single frame.** `i_start` with `i_data`=8'hA5 → 8 `o_sclk` rises. `o_sdout` sampled at the rises reads 1,0,1,0,0,1,0,1. `o_done` pulses at edge N+37. `o_sclk` is low for 4 cycles before it.
- **Back-to-back.** Assert `i_start` (8'h3C) on the `o_done` edge → the second frame starts with no extra gap. A shadow receiver (backend-style) decodes 8'hA5 then 8'h3C.
- **Ignored start.** Pulse `i_start` with 8'hFF mid-frame → the frame in progress is unchanged. Exactly one `o_done`; no second frame.
- **Abort.** Drop `i_ready` after the 3rd `o_sclk` rise → `o_err` pulses next cycle, `o_sclk`=`o_sdout`=0, no `o_done`. Raising `i_ready` returns the block to IDLE.
- **Reset mid-frame, plus sync.** Assert `i_resetbFPGA` mid-SHIFT → all outputs hit reset values with no clock edge. Separately, toggle `i_vco1_fast` asynchronously → `o_vco1_fast_sync` follows within 3 cycles.

Source files
------------

// File: rtl/cfg_serial_tx.sv
// cfg_serial_tx: FPGA-side initiator of the backend configuration link.
// It holds the backend in reset for a fixed number of cycles after the FPGA
// leaves reset, then waits for the backend to report ready. Once the backend is
// ready, it shifts configuration frames out MSB-first on a slow serial clock
// and data pair. It also brings the backend's asynchronous VCO status flag
// into the i_mainclk domain.
//
// Ports:
//   i_mainclk        - single clock, all logic on the rising edge
//   i_resetbFPGA     - asynchronous active-low reset
//   i_start          - one-cycle request to send i_data (taken only when idle)
//   i_data           - frame payload, captured on the accepting edge
//   i_ready          - backend ready (same clock domain)
//   i_vco1_fast      - backend VCO status (asynchronous)
//   o_resetbAll      - active-low reset to the backend
//   o_sclk           - serial clock, idles low
//   o_sdout          - serial data, updated only on the edge that drives o_sclk low
//   o_busy           - high in every state except IDLE
//   o_done           - one-cycle pulse when a frame completes
//   o_err            - one-cycle pulse when a frame is aborted
//   o_vco1_fast_sync - i_vco1_fast after a two-flop synchroniser
//
// Parameters: DATA_W >= 2, SCLK_DIV >= 1, GAP_CYCLES >= 1, RST_HOLD >= 1.
module cfg_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int SCLK_DIV   = 2,
  parameter int GAP_CYCLES = 4,
  parameter int RST_HOLD   = 4
) (
  input  logic              i_mainclk,
  input  logic              i_resetbFPGA,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  input  logic              i_vco1_fast,
  output logic              o_resetbAll,
  output logic              o_sclk,
  output logic              o_sdout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_vco1_fast_sync
);

  localparam int DIV_W = $clog2(2 * SCLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RST_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    RST_WAIT,
    WAIT_READY,
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt, div_inc;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              resetb_nxt, sclk_nxt, sdout_nxt, busy_nxt, done_nxt, err_nxt;
  logic              vco_meta;

  // State, counters and every output are registered together so that the
  // outputs are glitch-free and change in step with the state.
  always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
    if (!i_resetbFPGA) begin
      state       <= RST_WAIT;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      rst_cnt     <= '0;
      shreg       <= '0;
      o_resetbAll <= 1'b0;
      o_sclk      <= 1'b0;
      o_sdout     <= 1'b0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      gap_cnt     <= gap_nxt;
      rst_cnt     <= rst_nxt;
      shreg       <= shreg_nxt;
      o_resetbAll <= resetb_nxt;
      o_sclk      <= sclk_nxt;
      o_sdout     <= sdout_nxt;
      o_busy      <= busy_nxt;
      o_done      <= done_nxt;
      o_err       <= err_nxt;
    end
  end

  // Next-state and next-output logic. The shift register holds the bits still
  // to be sent, left-aligned, so its MSB is always the next bit for o_sdout.
  // The first bit goes straight from i_data to o_sdout on the accepting edge.
  // Losing i_ready during a frame takes priority over all other activity,
  // including a GAP that would otherwise finish on the same edge.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    gap_nxt    = gap_cnt;
    rst_nxt    = rst_cnt;
    shreg_nxt  = shreg;
    resetb_nxt = o_resetbAll;
    sclk_nxt   = o_sclk;
    sdout_nxt  = o_sdout;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    div_inc    = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    if ((state == SHIFT || state == GAP) && !i_ready) begin
      state_nxt = WAIT_READY;
      sclk_nxt  = 1'b0;
      sdout_nxt = 1'b0;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        RST_WAIT: begin
          if (rst_cnt == RST_LAST) begin
            resetb_nxt = 1'b1;
            state_nxt  = WAIT_READY;
          end else begin
            rst_nxt = rst_cnt + 1'b1;
          end
        end
        WAIT_READY: begin
          if (i_ready) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
        IDLE: begin
          if (!i_ready) begin
            state_nxt = WAIT_READY;
            busy_nxt  = 1'b1;
          end else if (i_start) begin
            state_nxt = SHIFT;
            busy_nxt  = 1'b1;
            div_nxt   = '0;
            bit_nxt   = '0;
            sclk_nxt  = 1'b0;
            sdout_nxt = i_data[DATA_W-1];
            shreg_nxt = {i_data[DATA_W-2:0], 1'b0};
          end
        end
        SHIFT: begin
          div_nxt = div_inc;
          if (div_cnt == DIV_LAST) begin
            sclk_nxt = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              sdout_nxt = 1'b0;
              gap_nxt   = '0;
              state_nxt = GAP;
            end else begin
              bit_nxt   = bit_cnt + 1'b1;
              sdout_nxt = shreg[DATA_W-1];
              shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
            end
          end else begin
            sclk_nxt = (div_inc >= DIV_HALF);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap_cnt + 1'b1;
          end
        end
        default: state_nxt = RST_WAIT;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous VCO status flag.
  always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
    if (!i_resetbFPGA) begin
      vco_meta         <= 1'b0;
      o_vco1_fast_sync <= 1'b0;
    end else begin
      vco_meta         <= i_vco1_fast;
      o_vco1_fast_sync <= vco_meta;
    end
  end

endmodule

// File: tb/tb_cfg_serial_tx.sv
// tb_cfg_serial_tx: self-checking bench for cfg_serial_tx with default
// parameters. A shadow receiver decodes frames on o_sclk rising edges and
// compares them against a queue of payloads pushed when each start is driven.
module tb_cfg_serial_tx;

  localparam int DATA_W     = 8;
  localparam int SCLK_DIV   = 2;
  localparam int GAP_CYCLES = 4;
  localparam int RST_HOLD   = 4;
  localparam int DONE_K     = 1 + 2 * SCLK_DIV * DATA_W + GAP_CYCLES;
  localparam int TIMEOUT    = 200;

  logic              i_mainclk;
  logic              i_resetbFPGA;
  logic              i_start;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic              i_vco1_fast;
  logic              o_resetbAll;
  logic              o_sclk;
  logic              o_sdout;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_vco1_fast_sync;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int   done_k;
    int   rises;
    int   low_run;
    int   first_rise_k;
    logic sdout_k1;
    logic busy_k1;
  } frame_res_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                mid_k;
    logic [DATA_W-1:0] mid_data;
    int                exp_done_k;
    int                exp_rises;
    int                exp_low_run;
    int                exp_first_rise;
    logic              exp_sdout_k1;
  } vec_t;

  vec_t vecs[5];

  cfg_serial_tx #(
    .DATA_W    (DATA_W),
    .SCLK_DIV  (SCLK_DIV),
    .GAP_CYCLES(GAP_CYCLES),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .i_mainclk       (i_mainclk),
    .i_resetbFPGA    (i_resetbFPGA),
    .i_start         (i_start),
    .i_data          (i_data),
    .i_ready         (i_ready),
    .i_vco1_fast     (i_vco1_fast),
    .o_resetbAll     (o_resetbAll),
    .o_sclk          (o_sclk),
    .o_sdout         (o_sdout),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_vco1_fast_sync(o_vco1_fast_sync)
  );

  initial begin
    i_mainclk = 1'b0;
    forever #5 i_mainclk = ~i_mainclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  // Drives one start from the current falling edge and follows the frame
  // until o_done, optionally pulsing a second start partway through.
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input int mid_k,
                               input logic [DATA_W-1:0] mid_data,
                               output frame_res_t res);
    logic prev;
    res = '{done_k: 0, rises: 0, low_run: 0, first_rise_k: 0,
            sdout_k1: 1'b0, busy_k1: 1'b0};
    checkOutput("busy_before_start", o_busy, 0);
    i_start = 1'b1;
    i_data  = data;
    exp_q.push_back(data);
    prev = o_sclk;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge i_mainclk);
      if (k == 1) begin
        i_start      = 1'b0;
        i_data       = '0;
        res.sdout_k1 = o_sdout;
        res.busy_k1  = o_busy;
      end
      if (k == mid_k) begin
        i_start = 1'b1;
        i_data  = mid_data;
      end
      if (k == mid_k + 1) i_start = 1'b0;
      if (o_done) begin
        res.done_k = k;
        break;
      end
      if (o_sclk && !prev) begin
        res.rises++;
        if (res.first_rise_k == 0) res.first_rise_k = k;
      end
      if (!o_sclk) res.low_run++;
      else res.low_run = 0;
      prev = o_sclk;
    end
  endtask

  // Shadow backend receiver: samples o_sdout on each o_sclk rise and compares
  // completed frames against the scoreboard; an abort discards the frame.
  logic              rx_prev_sclk;
  logic [DATA_W-1:0] rx_word;
  int                rx_bits;
  always @(negedge i_mainclk) begin
    if (!i_resetbFPGA) begin
      rx_bits      = 0;
      rx_prev_sclk = 1'b0;
    end else begin
      if (o_err) begin
        rx_bits = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (o_sclk && !rx_prev_sclk) begin
        rx_word = {rx_word[DATA_W-2:0], o_sdout};
        rx_bits++;
        if (rx_bits == DATA_W) begin
          rx_bits = 0;
          checkOutput("rx_frame_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) checkOutput("rx_word", rx_word, exp_q.pop_front());
        end
      end
      rx_prev_sclk = o_sclk;
    end
  end

  initial begin
    frame_res_t res;
    int rises, done_cnt, err_cnt;
    logic prev, found;

    vecs[0] = '{8'hA5, 0, 8'h00, DONE_K, DATA_W, GAP_CYCLES, SCLK_DIV + 1, 1'b1};
    vecs[1] = '{8'h3C, 0, 8'h00, DONE_K, DATA_W, GAP_CYCLES, SCLK_DIV + 1, 1'b0};
    vecs[2] = '{8'h00, 0, 8'h00, DONE_K, DATA_W, GAP_CYCLES, SCLK_DIV + 1, 1'b0};
    vecs[3] = '{8'hFF, 0, 8'h00, DONE_K, DATA_W, GAP_CYCLES, SCLK_DIV + 1, 1'b1};
    vecs[4] = '{8'h5A, 10, 8'hFF, DONE_K, DATA_W, GAP_CYCLES, SCLK_DIV + 1, 1'b0};

    i_resetbFPGA = 1'b0;
    i_start      = 1'b0;
    i_data       = '0;
    i_ready      = 1'b0;
    i_vco1_fast  = 1'b0;

    // Reset values while reset is held.
    @(negedge i_mainclk);
    @(negedge i_mainclk);
    checkOutput("rst_resetbAll", o_resetbAll, 0);
    checkOutput("rst_sclk", o_sclk, 0);
    checkOutput("rst_sdout", o_sdout, 0);
    checkOutput("rst_busy", o_busy, 1);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_sync", o_vco1_fast_sync, 0);

    // Reset release: backend reset held low for RST_HOLD cycles.
    i_resetbFPGA = 1'b1;
    for (int k = 1; k <= RST_HOLD + 2; k++) begin
      @(negedge i_mainclk);
      checkOutput($sformatf("rst_hold_k%0d", k), o_resetbAll, (k >= RST_HOLD));
    end
    checkOutput("busy_wait_ready", o_busy, 1);
    i_ready = 1'b1;
    @(negedge i_mainclk);
    checkOutput("busy_after_ready", o_busy, 0);

    // Frames run back-to-back: each start is driven on the o_done cycle.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].mid_k, vecs[i].mid_data, res);
      checkOutput($sformatf("v%0d_done_k", i), res.done_k, vecs[i].exp_done_k);
      checkOutput($sformatf("v%0d_rises", i), res.rises, vecs[i].exp_rises);
      checkOutput($sformatf("v%0d_gap_low", i), res.low_run, vecs[i].exp_low_run);
      checkOutput($sformatf("v%0d_first_rise", i), res.first_rise_k, vecs[i].exp_first_rise);
      checkOutput($sformatf("v%0d_sdout_first", i), res.sdout_k1, vecs[i].exp_sdout_k1);
      checkOutput($sformatf("v%0d_busy_first", i), res.busy_k1, 1);
    end

    // After the ignored mid-frame start: no second frame follows.
    done_cnt = 0;
    rises = 0;
    prev = o_sclk;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_mainclk);
      if (o_done) done_cnt++;
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
    end
    checkOutput("ignored_extra_done", done_cnt, 0);
    checkOutput("ignored_extra_rises", rises, 0);
    checkOutput("ignored_busy_idle", o_busy, 0);
    checkOutput("sb_empty_after_frames", exp_q.size(), 0);

    // Abort: drop i_ready after the third o_sclk rise.
    i_start = 1'b1;
    i_data  = 8'hC3;
    exp_q.push_back(8'hC3);
    rises = 0;
    prev  = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge i_mainclk);
      if (k == 1) i_start = 1'b0;
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
      if (rises == 3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_third_rise", found, 1);
    i_ready = 1'b0;
    @(negedge i_mainclk);
    checkOutput("abort_err", o_err, 1);
    checkOutput("abort_sclk", o_sclk, 0);
    checkOutput("abort_sdout", o_sdout, 0);
    checkOutput("abort_done", o_done, 0);
    checkOutput("abort_busy", o_busy, 1);
    done_cnt = 0;
    err_cnt  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_mainclk);
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_single_err", err_cnt, 0);
    checkOutput("abort_wait_busy", o_busy, 1);
    i_ready = 1'b1;
    @(negedge i_mainclk);
    checkOutput("abort_recover_idle", o_busy, 0);
    checkOutput("sb_empty_after_abort", exp_q.size(), 0);

    // Asynchronous reset in the middle of a frame.
    i_start = 1'b1;
    i_data  = 8'h99;
    exp_q.push_back(8'h99);
    @(negedge i_mainclk);
    i_start = 1'b0;
    repeat (9) @(negedge i_mainclk);
    checkOutput("midrst_pre_busy", o_busy, 1);
    checkOutput("midrst_pre_resetbAll", o_resetbAll, 1);
    #3;
    i_resetbFPGA = 1'b0;
    #1;
    checkOutput("midrst_resetbAll", o_resetbAll, 0);
    checkOutput("midrst_sclk", o_sclk, 0);
    checkOutput("midrst_sdout", o_sdout, 0);
    checkOutput("midrst_busy", o_busy, 1);
    checkOutput("midrst_done", o_done, 0);
    checkOutput("midrst_err", o_err, 0);
    exp_q.delete();
    @(negedge i_mainclk);
    @(negedge i_mainclk);
    i_resetbFPGA = 1'b1;

    // VCO status synchroniser, changed between clock edges.
    #3;
    i_vco1_fast = 1'b1;
    @(posedge i_mainclk);
    #1;
    checkOutput("sync_rise_early", o_vco1_fast_sync, 0);
    @(posedge i_mainclk);
    @(posedge i_mainclk);
    #1;
    checkOutput("sync_rise", o_vco1_fast_sync, 1);
    #3;
    i_vco1_fast = 1'b0;
    @(posedge i_mainclk);
    #1;
    checkOutput("sync_fall_early", o_vco1_fast_sync, 1);
    @(posedge i_mainclk);
    @(posedge i_mainclk);
    #1;
    checkOutput("sync_fall", o_vco1_fast_sync, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
